// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT-DIV path: funct3 codes, divide-issue FSM
// states and the RV32M divide corner-case constants.
package muldiv_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Quotient returned for a zero divisor, and the most negative RV32 value
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_FIX,
    S_RESP
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divider: builds operand
// magnitudes and re-applies the RV32M sign rules to the raw result.
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_signed,
  input  logic            is_quot,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic [XLEN-1:0] res
);

  logic neg_a, neg_b, flip;

  assign neg_a = is_signed & rs1[XLEN-1];
  assign neg_b = is_signed & rs2[XLEN-1];

  // Most-negative value negates to itself, which is the correct unsigned magnitude
  assign mag_a = neg_a ? ('0 - rs1) : rs1;
  assign mag_b = neg_b ? ('0 - rs2) : rs2;

  // Quotient takes the xor of operand signs; remainder follows the dividend
  assign flip = is_quot ? (neg_a ^ neg_b) : neg_a;
  assign res  = flip ? ('0 - raw) : raw;

endmodule

// File: rtl/div_issue_ctrl.sv
// RV32M divide issue controller: resolves zero-divisor, signed-overflow and
// illegal-funct3 cases locally, drives the unsigned divider with magnitudes
// and sign-corrects its result before handing it to writeback.
// Optional DIV_PAIR_CACHE_EN: fetches both quotient and remainder per issue
// and answers a repeat of the same operands from the cached pair.
module div_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dbz,
  output logic             rsp_err,
  output logic             busy,
  output logic             enable_div,
  output logic [XLEN-1:0]  div_oper_a,
  output logic [XLEN-1:0]  div_oper_b,
  output logic             div_fuct3,
  input  logic [XLEN-1:0]  div_o,
  input  logic             div_finish,
  input  logic             divided_by_zero
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic [2:0]       f3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
  } req_t;

  div_state_e       state, state_nx;
  req_t             rq;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  res_q, fix_raw, mag_a, mag_b, fixed;
  logic             dbz_q, err_q;
  logic             is_sgn, is_quot, legal, zero_div, ovf, special;
  logic             hit, cur_quot, last_pass;

  // Zero divisors never reach the divider, so its flag carries no information
  logic unused_dbz;
  assign unused_dbz = divided_by_zero;

  assign is_sgn   = ~rq.f3[0];
  assign is_quot  = ~rq.f3[1];
  assign legal    = rq.f3[2];
  assign zero_div = (rq.rs2 == '0);
  assign ovf      = is_sgn && (rq.rs1 == INT_MIN) && (rq.rs2 == '1);
  assign special  = !legal || zero_div || ovf;

`ifdef DIV_PAIR_CACHE_EN
  logic            c_vld, c_sgn, pass2;
  logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r;
  assign hit       = c_vld && (c_sgn == is_sgn) && (c_rs1 == rq.rs1) && (c_rs2 == rq.rs2);
  assign cur_quot  = is_quot ^ pass2;
  assign last_pass = pass2;
  assign fix_raw   = is_quot ? c_q : c_r;
`else
  logic [XLEN-1:0] raw_q;
  assign hit       = 1'b0;
  assign cur_quot  = is_quot;
  assign last_pass = 1'b1;
  assign fix_raw   = raw_q;
`endif

  div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .rs1       (rq.rs1),
    .rs2       (rq.rs2),
    .is_signed (is_sgn),
    .is_quot   (is_quot),
    .raw       (fix_raw),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .res       (fixed)
  );

  // State register; reset drops enable_div to the divider immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    enable_div = 1'b0;
    div_oper_a = '0;
    div_oper_b = '0;
    div_fuct3  = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (special)  state_nx = S_RESP;
        else if (hit) state_nx = S_FIX;
        else          state_nx = S_WAIT;
      end
      S_WAIT: begin
        enable_div = 1'b1;
        div_oper_a = mag_a;
        div_oper_b = mag_b;
        div_fuct3  = cur_quot;
        if (div_finish)          state_nx = last_pass ? S_FIX : S_WAIT;
        else if (cnt == TO_LAST) state_nx = S_RESP;
      end
      S_FIX: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, special-case results, divider capture and sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq    <= '0;
      cnt   <= '0;
      res_q <= '0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
`ifdef DIV_PAIR_CACHE_EN
      c_vld <= 1'b0;
      c_sgn <= 1'b0;
      pass2 <= 1'b0;
      c_rs1 <= '0;
      c_rs2 <= '0;
      c_q   <= '0;
      c_r   <= '0;
`else
      raw_q <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          rq    <= '{f3: req_funct3, rs1: req_rs1, rs2: req_rs2, tag: req_tag};
          dbz_q <= 1'b0;
          err_q <= 1'b0;
        end
        S_CHECK: begin
          cnt <= '0;
          if (!legal) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else if (zero_div) begin
            res_q <= is_quot ? DIV_ZERO_Q : rq.rs1;
            dbz_q <= 1'b1;
          end else if (ovf) begin
            res_q <= is_quot ? INT_MIN : '0;
          end
`ifdef DIV_PAIR_CACHE_EN
          else if (!hit) begin
            // Pair is only trusted once both passes land
            c_vld <= 1'b0;
            c_sgn <= is_sgn;
            c_rs1 <= rq.rs1;
            c_rs2 <= rq.rs2;
            pass2 <= 1'b0;
          end
`endif
        end
        S_WAIT: begin
          if (div_finish) begin
`ifdef DIV_PAIR_CACHE_EN
            if (cur_quot) c_q <= div_o;
            else          c_r <= div_o;
            cnt   <= '0;
            pass2 <= 1'b1;
            if (pass2) c_vld <= 1'b1;
`else
            raw_q <= div_o;
`endif
          end else if (cnt == TO_LAST) begin
            res_q <= '0;
            err_q <= 1'b1;
`ifdef DIV_PAIR_CACHE_EN
            c_vld <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: res_q <= fixed;
        default: ;
      endcase
    end
  end

  assign rsp_data = res_q;
  assign rsp_tag  = rq.tag;
  assign rsp_dbz  = dbz_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic model.
module tb_div_issue_ctrl;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_rs1, req_rs2, rsp_data, div_oper_a, div_oper_b, div_o;
  logic [TAG_W-1:0] req_tag, rsp_tag;
  logic             rsp_dbz, rsp_err, busy, enable_div, div_fuct3, div_finish;
  logic             divided_by_zero, stray_fin;

  div_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err), .busy(busy),
    .enable_div(enable_div), .div_oper_a(div_oper_a), .div_oper_b(div_oper_b),
    .div_fuct3(div_fuct3), .div_o(div_o), .div_finish(div_finish),
    .divided_by_zero(divided_by_zero)
  );

  // Divider model: finishes in the div_lat-th consecutive enabled cycle
  int div_lat;
  int en_cnt;
  assign div_finish = (enable_div && (en_cnt == div_lat - 1)) || stray_fin;
  assign div_o = div_fuct3 ? ((div_oper_b == 0) ? '1 : div_oper_a / div_oper_b)
                           : ((div_oper_b == 0) ? div_oper_a : div_oper_a % div_oper_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        en_cnt <= 0;
    else if (!enable_div || div_finish) en_cnt <= 0;
    else                               en_cnt <= en_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural RV32M result
  function automatic void ref_op(input logic [2:0] f3, input logic [31:0] a, b,
                                 output logic [31:0] d, output bit dbz, output bit err);
    bit sgn = ~f3[0];
    bit quot = ~f3[1];
    int sa = a;
    int sb = b;
    dbz = 0; err = 0;
    if (!f3[2]) begin d = 0; err = 1; end
    else if (b == 0) begin d = quot ? 32'hFFFF_FFFF : a; dbz = 1; end
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = quot ? a : 32'h0;
    else if (sgn) d = quot ? sa / sb : sa % sb;
    else d = quot ? a / b : a % b;
  endfunction

  // Pair-cache shadow (only consulted when the feature is built in)
  bit m_cvld = 0;
  bit m_sgn;
  logic [31:0] m_a, m_b;

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, b, input logic [4:0] tag,
                        input int d, input int hold, input logic [31:0] ed, input bit edbz, eerr);
    int lat, en_n, exp_lat, exp_en;
    bit seen_en, special, sgn, q;
    logic [31:0] ea, eb;
    sgn = ~f3[0];
    q = ~f3[1];
    special = !f3[2] || b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (special) begin exp_lat = 2; exp_en = 0; end
`ifdef DIV_PAIR_CACHE_EN
    else if (m_cvld && m_a == a && m_b == b && m_sgn == sgn) begin exp_lat = 3; exp_en = 0; end
    else if (d > TO) begin exp_lat = 2 + TO; exp_en = TO; m_cvld = 0; end
    else begin
      exp_lat = 3 + 2 * d; exp_en = 2 * d;
      m_cvld = 1; m_a = a; m_b = b; m_sgn = sgn;
    end
`else
    else if (d > TO) begin exp_lat = 2 + TO; exp_en = TO; end
    else begin exp_lat = 3 + d; exp_en = d; end
`endif
    ea = (sgn && a[31]) ? -a : a;
    eb = (sgn && b[31]) ? -b : b;

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tag; div_lat = d;
    @(negedge clk);
    req_valid = 0;
    lat = 1; en_n = 0; seen_en = 0;
    while (!rsp_valid && lat < 400) begin
      if (enable_div) begin
        if (!seen_en) begin
          chk("oper_a", div_oper_a, ea);
          chk("oper_b", div_oper_b, eb);
          chk("div_fuct3", 32'(div_fuct3), 32'(q));
        end
        seen_en = 1;
        en_n++;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("enable_cycles", en_n, exp_en);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    chk("rsp_dbz", 32'(rsp_dbz), 32'(edbz));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("post_hs_valid", 32'(rsp_valid), 0);
    chk("post_hs_ready", 32'(req_ready), 1);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          d;
    logic [31:0] ed;
    bit          edbz, eerr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] ed, a, b;
    logic [2:0] f3;
    bit edbz, eerr;
    int k;

    req_valid = 0; req_funct3 = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0;
    rsp_ready = 0; divided_by_zero = 0; stray_fin = 0; div_lat = 1;

    tbl.push_back('{F3_DIV,  32'd7,         32'd3,         4, 32'd2,         0, 0});
    tbl.push_back('{F3_REM,  32'hFFFF_FFF9, 32'd3,         3, 32'hFFFF_FFFF, 0, 0});
    tbl.push_back('{F3_DIV,  32'd7,         32'hFFFF_FFFD, 2, 32'hFFFF_FFFE, 0, 0});
    tbl.push_back('{F3_DIVU, 32'hFFFF_FFF9, 32'd0,         1, 32'hFFFF_FFFF, 1, 0});
    tbl.push_back('{F3_REMU, 32'hFFFF_FFF9, 32'd0,         1, 32'hFFFF_FFF9, 1, 0});
    tbl.push_back('{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0});
    tbl.push_back('{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0,         0, 0});
    tbl.push_back('{F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0});
    tbl.push_back('{F3_DIV,  32'h8000_0000, 32'd2,         1, 32'hC000_0000, 0, 0});
    tbl.push_back('{F3_DIV,  32'd0,         32'd0,         1, 32'hFFFF_FFFF, 1, 0});
    tbl.push_back('{3'b001,  32'd9,         32'd3,         1, 32'h0,         0, 1});

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_enable_div", 32'(enable_div), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {30'b0, rsp_dbz, rsp_err}, 0);
    chk("rst_oper_a", div_oper_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i), tbl[i].d, 0, tbl[i].ed, tbl[i].edbz, tbl[i].eerr);

    // Stray div_finish in IDLE must not start anything
    @(negedge clk); stray_fin = 1;
    @(negedge clk); stray_fin = 0;
    chk("stray_busy", 32'(busy), 0);
    chk("stray_rsp_valid", 32'(rsp_valid), 0);

    // Writeback back-pressure for 5 cycles
    run_op(F3_DIV, 32'd100, 32'd7, 5'd20, 2, 5, 32'd14, 0, 0);

    // Divider never answers
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd21, 1000, 0, 32'd0, 0, 1);

    // Reset pulse while waiting on the divider
    @(negedge clk);
    req_valid = 1; req_funct3 = F3_DIVU; req_rs1 = 50; req_rs2 = 5; req_tag = 3; div_lat = 1000;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!enable_div && k < 10) begin @(negedge clk); k++; end
    chk("rstmid_reached_wait", 32'(enable_div), 1);
    rst_n = 0;
    #1;
    chk("rstmid_enable_div", 32'(enable_div), 0);
    chk("rstmid_req_ready", 32'(req_ready), 1);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
    m_cvld = 0;
    @(negedge clk); rst_n = 1;
    run_op(F3_REMU, 32'd50, 32'd7, 5'd22, 3, 0, 32'd1, 0, 0);

`ifdef DIV_PAIR_CACHE_EN
    run_op(F3_DIV, 32'd3025, 32'd12, 5'd23, 3, 0, 32'd252, 0, 0);
    run_op(F3_REM, 32'd3025, 32'd12, 5'd24, 3, 0, 32'd1, 0, 0);
`endif

    // Randomized ops checked against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(4, 7));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 100);
        1: a = -$urandom_range(1, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      ref_op(f3, a, b, ed, edbz, eerr);
      run_op(f3, a, b, 5'($urandom), $urandom_range(1, 6), $urandom_range(0, 2), ed, edbz, eerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
